// File: rtl/tbus_receiver.sv
// tbus_receiver: receiving end of the inverting tristate data bus.
// Captures active-low byte beats with a four-phase STB/ACK handshake and
// assembles them into a word presented on a valid/ready output.
// Optional feature macro: TBUS_PARITY_EN (adds BUS_PAR and per-word odd-parity
// checking reported on PAR_ERR; without it PAR_ERR is tied to 0).
module tbus_receiver #(
  parameter int BEATS  = 4,
  parameter int BEAT_W = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [BEAT_W-1:0]       nBUS_D,
  input  logic                    BUS_STB,
  input  logic                    BUS_LAST,
`ifdef TBUS_PARITY_EN
  input  logic                    BUS_PAR,
`endif
  output logic                    BUS_ACK,
  output logic [BEATS*BEAT_W-1:0] WORD,
  output logic [2:0]              WORD_LEN,
  output logic                    WORD_VALID,
  input  logic                    WORD_READY,
  output logic                    PAR_ERR
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [BEATS*BEAT_W-1:0] partial;
  logic [BEATS*BEAT_W-1:0] merged;
  logic [BEAT_W-1:0]       data;
  logic                    capture;
  logic                    final_beat;

  // Restore true polarity, decide whether this edge captures, and build the
  // partial word with the current beat dropped into lane cnt.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    data       = ~nBUS_D;
    capture    = BUS_STB & ~BUS_ACK & ~WORD_VALID;
    final_beat = BUS_LAST | (cnt == LAST_CNT);
    merged     = partial;
    for (int i = 0; i < BEATS; i++) begin
      if (cnt == CNT_W'(i)) merged[i*BEAT_W +: BEAT_W] = data;
    end
  end

  // Handshake, beat counter, partial-word accumulation and word output.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the partial-word register is reset (unlike a RAM) because lanes
      // above the final beat must read as 0 in the delivered word.
      BUS_ACK    <= 1'b0;
      WORD       <= '0;
      WORD_LEN   <= 3'd0;
      WORD_VALID <= 1'b0;
      cnt        <= '0;
      partial    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (capture) begin
        BUS_ACK <= 1'b1;
        if (final_beat) begin
          WORD       <= merged;
          WORD_LEN   <= 3'(cnt) + 3'd1;
          WORD_VALID <= 1'b1;
          cnt        <= '0;
          partial    <= '0;
        end else begin
          partial <= merged;
          cnt     <= cnt + 1'b1;
        end
      end else begin
        if (!BUS_STB)   BUS_ACK    <= 1'b0;
        if (WORD_READY) WORD_VALID <= 1'b0;
      end
    end
  end

`ifdef TBUS_PARITY_EN
  logic err_flag;
  logic beat_bad;

  // A beat is bad when data and parity bit together have even weight.
  always_comb begin
    beat_bad = ~(^data ^ BUS_PAR);
  end

  // Sticky per-word parity flag, transferred to PAR_ERR with the word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_flag <= 1'b0;
      PAR_ERR  <= 1'b0;
    end else if (capture) begin
      if (final_beat) begin
        PAR_ERR  <= err_flag | beat_bad;
        err_flag <= 1'b0;
      end else begin
        err_flag <= err_flag | beat_bad;
      end
    end
  end
`else
  assign PAR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_tbus_receiver.sv
// Testbench for tbus_receiver: directed vector table, hand-written corner
// sequences (backpressure, ACK hold, async reset) and a randomized
// sender/consumer run checked against a word-level reference queue.
module tb_tbus_receiver;

`ifdef TBUS_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  nBUS_D;
  logic        BUS_STB;
  logic        BUS_LAST;
  logic        par_drv;
  logic        BUS_ACK;
  logic [31:0] WORD;
  logic [2:0]  WORD_LEN;
  logic        WORD_VALID;
  logic        WORD_READY;
  logic        PAR_ERR;

  tbus_receiver #(.BEATS(4), .BEAT_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .nBUS_D    (nBUS_D),
    .BUS_STB   (BUS_STB),
    .BUS_LAST  (BUS_LAST),
`ifdef TBUS_PARITY_EN
    .BUS_PAR   (par_drv),
`endif
    .BUS_ACK   (BUS_ACK),
    .WORD      (WORD),
    .WORD_LEN  (WORD_LEN),
    .WORD_VALID(WORD_VALID),
    .WORD_READY(WORD_READY),
    .PAR_ERR   (PAR_ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Odd parity: data together with the parity bit has odd weight.
  function automatic logic good_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  // Directed vectors: one beat per record, expected outputs on word completion.
  typedef struct {
    logic [7:0]  nd;
    logic        last;
    logic        bad;
    logic        done;
    logic [31:0] exp_word;
    logic [2:0]  exp_len;
    logic        exp_perr;
  } vec_t;

  vec_t tbl[10];

  // Reference queue for the random phase: whole words as the sender built them.
  typedef struct {
    logic [31:0] word;
    logic [2:0]  len;
    logic        perr;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en      = 1'b0;
  bit   seen        = 1'b0;
  bit   sender_done = 1'b0;

  // Monitor: compare each newly presented word against the queue front.
  always @(negedge CLK) begin
    if (mon_en && WORD_VALID && !seen) begin
      if (exp_q.size() == 0) begin
        check("rnd_spurious_word", WORD_VALID, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rnd_word", WORD, e.word);
        check("rnd_len", WORD_LEN, e.len);
        check("rnd_perr", PAR_ERR, e.perr);
      end
      seen = 1'b1;
    end
    if (WORD_VALID && WORD_READY) seen = 1'b0;
  end

  task automatic run_sender();
    int          len;
    int          n;
    logic [7:0]  d[4];
    bit          bad[4];
    logic [31:0] word;
    bit          perr;
    exp_t        e;
    for (int w = 0; w < 60; w++) begin
      len  = $urandom_range(1, 4);
      word = '0;
      perr = 1'b0;
      for (int b = 0; b < len; b++) begin
        d[b]   = 8'($urandom);
        bad[b] = PAR_ON && ($urandom_range(0, 7) == 0);
        word   = word | (32'(d[b]) << (8 * b));
        perr   = perr | bad[b];
      end
      e.word = word;
      e.len  = 3'(len);
      e.perr = perr;
      exp_q.push_back(e);
      for (int b = 0; b < len; b++) begin
        nBUS_D   = ~d[b];
        par_drv  = good_par(d[b]) ^ bad[b];
        BUS_LAST = (b == len - 1) ? ((len < 4) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
        BUS_STB  = 1'b1;
        n = 0;
        do begin step(); n++; end while (BUS_ACK !== 1'b1 && n < 40);
        check("rnd_ack_rise", BUS_ACK, 1'b1);
        BUS_STB  = 1'b0;
        BUS_LAST = 1'b0;
        nBUS_D   = 8'($urandom);
        n = 0;
        do begin step(); n++; end while (BUS_ACK !== 1'b0 && n < 40);
        check("rnd_ack_fall", BUS_ACK, 1'b0);
        repeat ($urandom_range(0, 2)) step();
      end
    end
    sender_done = 1'b1;
  endtask

  task automatic run_consumer();
    int cyc = 0;
    do begin
      step();
      WORD_READY = ($urandom_range(0, 3) != 0);
      cyc++;
    end while (!(sender_done && exp_q.size() == 0 && !WORD_VALID) && cyc < 20000);
    WORD_READY = 1'b1;
  endtask

  initial begin
    // ~0xEF,~0xBE,~0xAD,~0xDE = 0x10,0x41,0x52,0x21 in lanes 0..3.
    tbl[0] = '{8'hEF, 1'b0, 1'b0, 1'b0, 32'h0,          3'd0, 1'b0};
    tbl[1] = '{8'hBE, 1'b0, 1'b0, 1'b0, 32'h0,          3'd0, 1'b0};
    tbl[2] = '{8'hAD, 1'b0, 1'b0, 1'b0, 32'h0,          3'd0, 1'b0};
    tbl[3] = '{8'hDE, 1'b0, 1'b0, 1'b1, 32'h21524110,   3'd4, 1'b0};
    tbl[4] = '{8'hFE, 1'b0, 1'b0, 1'b0, 32'h0,          3'd0, 1'b0};
    tbl[5] = '{8'hFD, 1'b1, 1'b0, 1'b1, 32'h00000201,   3'd2, 1'b0};
    // Parity word: beat 2 carries true 0x01 with the wrong parity bit; LAST
    // on beat 4 is redundant.
    tbl[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 32'h0,          3'd0, 1'b0};
    tbl[7] = '{8'hFE, 1'b0, 1'b1, 1'b0, 32'h0,          3'd0, 1'b0};
    tbl[8] = '{8'h7F, 1'b0, 1'b0, 1'b0, 32'h0,          3'd0, 1'b0};
    tbl[9] = '{8'hC3, 1'b1, 1'b0, 1'b1, 32'h3C8001FF,   3'd4, 1'b1};

    RST        = 1'b1;
    nBUS_D     = 8'h00;
    BUS_STB    = 1'b1;
    BUS_LAST   = 1'b0;
    par_drv    = 1'b0;
    WORD_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ack", BUS_ACK, 1'b0);
    check("rst_valid", WORD_VALID, 1'b0);
    check("rst_word", WORD, 32'h0);
    check("rst_len", WORD_LEN, 3'd0);
    check("rst_perr", PAR_ERR, 1'b0);
    @(negedge CLK);
    RST     = 1'b0;
    BUS_STB = 1'b0;
    step();

    // Table-driven beats, minimum beat period, consumer always ready.
    for (int i = 0; i < 10; i++) begin
      nBUS_D   = tbl[i].nd;
      BUS_LAST = tbl[i].last;
      par_drv  = good_par(~tbl[i].nd) ^ tbl[i].bad;
      BUS_STB  = 1'b1;
      step();
      check($sformatf("v%0d_ack_rise", i), BUS_ACK, 1'b1);
      check($sformatf("v%0d_valid", i), WORD_VALID, tbl[i].done);
      if (tbl[i].done) begin
        check($sformatf("v%0d_word", i), WORD, tbl[i].exp_word);
        check($sformatf("v%0d_len", i), WORD_LEN, tbl[i].exp_len);
        check($sformatf("v%0d_perr", i), PAR_ERR, tbl[i].exp_perr & PAR_ON);
      end
      BUS_STB  = 1'b0;
      BUS_LAST = 1'b0;
      step();
      check($sformatf("v%0d_ack_fall", i), BUS_ACK, 1'b0);
      check($sformatf("v%0d_valid_drop", i), WORD_VALID, 1'b0);
    end

    // Clean single-beat word after the parity word: error must not persist.
    nBUS_D = 8'h5A; BUS_LAST = 1'b1; par_drv = good_par(8'hA5); BUS_STB = 1'b1;
    step();
    check("clean_word", WORD, 32'h000000A5);
    check("clean_len", WORD_LEN, 3'd1);
    check("clean_perr", PAR_ERR, 1'b0);
    BUS_STB = 1'b0; BUS_LAST = 1'b0;
    step();

    // ACK hold: STB held high for 3 cycles captures exactly once.
    nBUS_D = 8'hFE; par_drv = good_par(8'h01); BUS_STB = 1'b1;
    step();
    check("hold_ack1", BUS_ACK, 1'b1);
    step();
    check("hold_ack2", BUS_ACK, 1'b1);
    step();
    check("hold_ack3", BUS_ACK, 1'b1);
    BUS_STB = 1'b0;
    step();
    check("hold_ack_fall", BUS_ACK, 1'b0);
    nBUS_D = 8'hFD; BUS_LAST = 1'b1; par_drv = good_par(8'h02); BUS_STB = 1'b1;
    step();
    check("hold_word", WORD, 32'h00000201);
    check("hold_len", WORD_LEN, 3'd2);
    BUS_STB = 1'b0; BUS_LAST = 1'b0;
    step();

    // Backpressure: pending word blocks the next beat until consumed.
    WORD_READY = 1'b0;
    nBUS_D = 8'h00; BUS_LAST = 1'b1; par_drv = good_par(8'hFF); BUS_STB = 1'b1;
    step();
    check("bp_first_valid", WORD_VALID, 1'b1);
    BUS_STB = 1'b0;
    step();
    nBUS_D = 8'hF0; par_drv = good_par(8'h0F); BUS_STB = 1'b1;
    step();
    check("bp_ack_blocked1", BUS_ACK, 1'b0);
    check("bp_valid_held", WORD_VALID, 1'b1);
    step();
    check("bp_ack_blocked2", BUS_ACK, 1'b0);
    check("bp_word_held", WORD, 32'h000000FF);
    WORD_READY = 1'b1;
    step();
    check("bp_accept_valid", WORD_VALID, 1'b0);
    check("bp_accept_noack", BUS_ACK, 1'b0);
    WORD_READY = 1'b0;
    step();
    check("bp_ack_rise", BUS_ACK, 1'b1);
    check("bp_valid2", WORD_VALID, 1'b1);
    check("bp_word2", WORD, 32'h0000000F);
    check("bp_len2", WORD_LEN, 3'd1);
    BUS_STB = 1'b0; BUS_LAST = 1'b0; WORD_READY = 1'b1;
    step();
    check("bp_final_ack", BUS_ACK, 1'b0);
    check("bp_final_valid", WORD_VALID, 1'b0);
    check("bp_word_kept", WORD, 32'h0000000F);

    // Reset with a word pending (bad parity when parity is built in).
    WORD_READY = 1'b0;
    nBUS_D = 8'hED; BUS_LAST = 1'b1; par_drv = ~good_par(8'h12); BUS_STB = 1'b1;
    step();
    BUS_STB = 1'b0; BUS_LAST = 1'b0;
    step();
    check("pend_valid", WORD_VALID, 1'b1);
    check("pend_perr", PAR_ERR, PAR_ON);
    #2 RST = 1'b1;
    #1;
    check("pend_rst_valid", WORD_VALID, 1'b0);
    check("pend_rst_word", WORD, 32'h0);
    check("pend_rst_len", WORD_LEN, 3'd0);
    check("pend_rst_perr", PAR_ERR, 1'b0);
    @(negedge CLK);
    RST = 1'b0; WORD_READY = 1'b1;
    step();

    // Reset mid-word with STB and ACK high; next word restarts at lane 0.
    nBUS_D = 8'h00; par_drv = good_par(8'hFF); BUS_STB = 1'b1;
    step();
    check("mid_ack", BUS_ACK, 1'b1);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_ack", BUS_ACK, 1'b0);
    @(negedge CLK);
    RST = 1'b0; BUS_STB = 1'b0;
    step();
    nBUS_D = 8'hF0; BUS_LAST = 1'b1; par_drv = good_par(8'h0F); BUS_STB = 1'b1;
    step();
    check("mid_after_valid", WORD_VALID, 1'b1);
    check("mid_after_word", WORD, 32'h0000000F);
    check("mid_after_len", WORD_LEN, 3'd1);
    BUS_STB = 1'b0; BUS_LAST = 1'b0;
    step();

    // Randomized sender and consumer against the reference queue.
    mon_en = 1'b1;
    seen   = 1'b0;
    fork
      run_sender();
      run_consumer();
    join
    step();
    mon_en = 1'b0;
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_idle_valid", WORD_VALID, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
